i2s_mic_rx: RTL and testbench
=============================

I2S_MIC_RX -- requirements
Module: i2s_mic_rx

Interface
REQ-001 Parameter: CLK_DIV, default 4, number of CLK cycles per SCK half-period; legal range 2..255.
REQ-002 Port: CLK  in  1  system clock; all logic on rising edge.
REQ-003 Port: RST  in  1  reset, synchronous, active-high.
REQ-004 Port: EN  in  1  run request; level-sensitive.
REQ-005 Port: SCK  out  1  I2S bit clock driven to both microphones.
REQ-006 Port: WS  out  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-007 Port: SD  in  1  shared serial data line from the left/right microphone pair.
REQ-008 Port: SDATA_L  out  24  last complete left sample.
REQ-009 Port: SDATA_R  out  24  last complete right sample.
REQ-010 Port: ENREADFRAME_L  out  1  one-CLK strobe; SDATA_L updated this cycle.
REQ-011 Port: ENREADFRAME_R  out  1  one-CLK strobe; SDATA_R updated this cycle.
REQ-012 Port: FRAME_CNT  out  16  completed stereo frames, wraps 0xFFFF->0x0000.

Function
REQ-013 States: IDLE and RUN; IDLE->RUN when EN=1; RUN->IDLE only at a frame boundary (REQ-021).
REQ-014 Divider: counts 0..CLK_DIV-1 in RUN; SCK toggles in the cycle after the count reaches CLK_DIV-1; SCK period = 2*CLK_DIV CLK cycles.
REQ-015 Bit counter b (6 bits, 0..63): advances on every SCK falling toggle; wraps 63->0.
REQ-016 WS = b[5]; updates together with the SCK falling toggle; WS period = 64 SCK periods.
REQ-017 Slot bit s = b[4:0]; SD is sampled in the CLK cycle of the SCK rising toggle.
REQ-018 Sampling: s = 1..24 shift into a 24-bit register MSB first (one-bit I2S delay); s = 0 and 25..31 are ignored.
REQ-019 Sample output: one CLK after the s=24 capture, load SDATA_L (b<32) or SDATA_R (b>=32) and assert the matching strobe for exactly one CLK.
REQ-020 FRAME_CNT: increments in the same cycle as ENREADFRAME_R.
REQ-021 EN deasserted in RUN: finish the current frame through b=63; at the next falling toggle (b would wrap to 0) enter IDLE with SCK=0, WS=0, divider=0, b=0.
REQ-022 EN reasserted before the frame boundary: stay in RUN with no gap.
REQ-023 IDLE: SCK=0, WS=0, strobes 0; SDATA_L, SDATA_R and FRAME_CNT hold their values.
REQ-024 IDLE->RUN: first SCK rising toggle occurs CLK_DIV cycles after entry; b starts at 0 (left slot).
REQ-025 ENREADFRAME_L and ENREADFRAME_R are never asserted in the same cycle.

Reset
REQ-026 RST=1 in any state (including mid-frame) forces next-edge state IDLE, SCK=0, WS=0, divider=0, b=0, shift register=0, SDATA_L=0, SDATA_R=0, both strobes 0, FRAME_CNT=0.
REQ-027 No partial sample captured before RST is ever output.
REQ-028 RST has priority over EN.

Configuration
REQ-029 Macro OFFSET_BINARY_EN defined: SDATA_L and SDATA_R carry offset binary (captured MSB inverted), so that unsigned comparison downstream is monotonic in signal level.
REQ-030 Macro OFFSET_BINARY_EN undefined: SDATA_L and SDATA_R carry the captured two's-complement bits unchanged.

Verification
REQ-031 CLK_DIV=2, EN=1; mic model drives L=0x123456, R=0xFEDCBA -> SDATA_L=0x123456 and SDATA_R=0xFEDCBA (0x923456 and 0x7EDCBA with OFFSET_BINARY_EN); each strobe has period 256 CLK; FRAME_CNT increments by 1 per frame.
REQ-032 CLK_DIV=4 -> SCK period 8 CLK; WS toggles every 256 CLK; WS edges coincide with SCK falling toggles.
REQ-033 EN dropped at b=10 -> the R sample of that frame is still delivered; then IDLE with SCK=0 and no further strobes; values held.
REQ-034 RST pulsed at b=40 -> all outputs 0 on the next edge; after release with EN=1, the first strobe is ENREADFRAME_L carrying a full new sample.
REQ-035 FRAME_CNT preloaded to 0xFFFF by running 65535 frames (or forced) -> the next frame yields 0x0000.
REQ-036 Mic model drives SD=1 in bits 0 and 25..31 of each slot, other bits 0 -> SDATA=0x000000 (0x800000 with OFFSET_BINARY_EN).

Source files
------------

// File: rtl/i2s_mic_rx.sv
// I2S stereo microphone receiver: SCK/WS master, 24-bit left/right capture.
// Optional OFFSET_BINARY_EN: output samples in offset binary instead of two's complement.
module i2s_mic_rx #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic        SCK,
  output logic        WS,
  input  logic        SD,
  output logic [23:0] SDATA_L,
  output logic [23:0] SDATA_R,
  output logic        ENREADFRAME_L,
  output logic        ENREADFRAME_R,
  output logic [15:0] FRAME_CNT
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_div;
  logic        r_sck;
  logic [5:0]  r_bit;
  logic [23:0] r_shift;
  logic        r_done;
  logic [23:0] r_sdata_l;
  logic [23:0] r_sdata_r;
  logic        r_stb_l;
  logic        r_stb_r;
  logic [15:0] r_frame_cnt;

  logic        w_run;
  logic        w_tick;
  logic        w_rise;
  logic        w_fall;
  logic        w_wrap;
  logic [4:0]  w_slot;
  logic        w_capture;
  logic        w_last;
  logic        w_load_l;
  logic        w_load_r;
  logic [23:0] w_sample;

  assign w_run     = (r_state == ST_RUN);
  assign w_tick    = w_run && (r_div == DIV_MAX);
  assign w_rise    = w_tick && !r_sck;
  assign w_fall    = w_tick && r_sck;
  assign w_wrap    = w_fall && (r_bit == 6'd63);
  assign w_slot    = r_bit[4:0];
  assign w_capture = w_rise
                  && (w_slot >= 5'd1)
                  && (w_slot <= 5'd24);
  assign w_last    = w_rise && (w_slot == 5'd24);

  // r_bit cannot move in the cycle after a rising toggle (CLK_DIV >= 2)
  assign w_load_l  = r_done && !r_bit[5];
  assign w_load_r  = r_done && r_bit[5];

`ifdef OFFSET_BINARY_EN
  assign w_sample  = {~r_shift[23], r_shift[22:0]};
`else
  assign w_sample  = r_shift;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (EN) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_wrap && !EN) begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // leaving RUN happens on the wrap toggle, which already zeroes all three
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div <= 8'd0;
      r_sck <= 1'b0;
      r_bit <= 6'd0;
    end else if (w_run) begin
      if (w_tick) begin
        r_div <= 8'd0;
        r_sck <= !r_sck;
        if (r_sck) begin
          r_bit <= r_bit + 6'd1;
        end
      end else begin
        r_div <= r_div + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_shift <= 24'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_capture) begin
        r_shift <= {r_shift[22:0], SD};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sdata_l   <= 24'd0;
      r_sdata_r   <= 24'd0;
      r_stb_l     <= 1'b0;
      r_stb_r     <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else begin
      r_stb_l <= w_load_l;
      r_stb_r <= w_load_r;
      if (w_load_l) begin
        r_sdata_l <= w_sample;
      end
      if (w_load_r) begin
        r_sdata_r   <= w_sample;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign SCK           = r_sck;
  assign WS            = r_bit[5];
  assign SDATA_L       = r_sdata_l;
  assign SDATA_R       = r_sdata_r;
  assign ENREADFRAME_L = r_stb_l;
  assign ENREADFRAME_R = r_stb_r;
  assign FRAME_CNT     = r_frame_cnt;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Bench for i2s_mic_rx: I2S microphone-pair model plus frame-level reference.
// Build with OFFSET_BINARY_EN to match the offset-binary variant of the DUT.
module tb_i2s_mic_rx;

  localparam int DIV   = 4;
  localparam int BITP  = 2 * DIV;
  localparam int HALF  = 32 * BITP;
  localparam int FRAME = 64 * BITP;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN  = 1'b0;
  logic        SD  = 1'b0;
  logic        SCK;
  logic        WS;
  logic [23:0] SDATA_L;
  logic [23:0] SDATA_R;
  logic        ENREADFRAME_L;
  logic        ENREADFRAME_R;
  logic [15:0] FRAME_CNT;

  i2s_mic_rx #(.CLK_DIV(DIV)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .EN            (EN),
    .SCK           (SCK),
    .WS            (WS),
    .SD            (SD),
    .SDATA_L       (SDATA_L),
    .SDATA_R       (SDATA_R),
    .ENREADFRAME_L (ENREADFRAME_L),
    .ENREADFRAME_R (ENREADFRAME_R),
    .FRAME_CNT     (FRAME_CNT)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // offset binary = two's complement value shifted up by half range
  function automatic logic [23:0] out_word(input logic [23:0] w);
`ifdef OFFSET_BINARY_EN
    return w + 24'h800000;
`else
    return w;
`endif
  endfunction

  int word_mode = 1;
  int fill_mode = 0;

  function automatic logic [23:0] pick(input logic ch);
    if (word_mode == 1) return ch ? 24'hFEDCBA : 24'h123456;
    if (word_mode == 2) return 24'h000000;
    return 24'($urandom);
  endfunction

  // microphone pair: a slot starts when WS changes on a falling SCK,
  // MSB follows one SCK later, 24 data bits, then filler
  int          mic_cnt = 0;
  logic        mic_ws  = 1'b0;
  logic        mic_psck = 1'b0;
  logic [23:0] mic_word [2];

  initial begin
    mic_word[0] = 24'h0;
    mic_word[1] = 24'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (RST) begin
        mic_cnt     = 0;
        mic_ws      = 1'b0;
        mic_word[0] = pick(1'b0);
      end else if (mic_psck && !SCK) begin
        if (WS !== mic_ws) begin
          mic_ws           = WS;
          mic_cnt          = 0;
          mic_word[mic_ws] = pick(mic_ws);
        end else begin
          mic_cnt++;
        end
      end
      mic_psck = SCK;
      if (mic_cnt >= 1 && mic_cnt <= 24)
        SD = mic_word[mic_ws][24 - mic_cnt];
      else
        SD = (fill_mode == 1) ? 1'b1 : 1'($urandom);
    end
  end

  int          cyc       = 0;
  int          last_rise = -1;
  int          last_ws   = -1;
  int          last_l    = -1;
  int          last_r    = -1;
  int          n_l       = 0;
  int          n_r       = 0;
  logic [15:0] model_cnt = 16'h0;
  logic [23:0] held_l    = 24'h0;
  logic [23:0] held_r    = 24'h0;
  logic        m_psck    = 1'b0;
  logic        m_pws     = 1'b0;

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (RST) begin
        check("rst_sck", 32'(SCK), 32'h0);
        check("rst_ws", 32'(WS), 32'h0);
        check("rst_sdata_l", 32'(SDATA_L), 32'h0);
        check("rst_sdata_r", 32'(SDATA_R), 32'h0);
        check("rst_stb_l", 32'(ENREADFRAME_L), 32'h0);
        check("rst_stb_r", 32'(ENREADFRAME_R), 32'h0);
        check("rst_fcnt", 32'(FRAME_CNT), 32'h0);
        last_rise = -1;
        last_ws   = -1;
        last_l    = -1;
        last_r    = -1;
        model_cnt = 16'h0;
        held_l    = 24'h0;
        held_r    = 24'h0;
      end else begin
        if (SCK && !m_psck) begin
          if (last_rise >= 0) check("sck_period", cyc - last_rise, BITP);
          last_rise = cyc;
        end
        if (WS !== m_pws) begin
          check("ws_on_sck_fall", 32'({m_psck, SCK}), 32'h2);
          if (last_ws >= 0) check("ws_period", cyc - last_ws, HALF);
          last_ws = cyc;
        end
        if (ENREADFRAME_L || ENREADFRAME_R)
          check("strobe_excl", 32'(ENREADFRAME_L & ENREADFRAME_R), 32'h0);
        if (ENREADFRAME_L) begin
          n_l++;
          held_l = out_word(mic_word[0]);
          check("sdata_l", 32'(SDATA_L), 32'(held_l));
          if (last_l >= 0) check("l_period", cyc - last_l, FRAME);
          last_l = cyc;
        end
        if (ENREADFRAME_R) begin
          n_r++;
          held_r    = out_word(mic_word[1]);
          model_cnt = model_cnt + 16'h1;
          check("sdata_r", 32'(SDATA_R), 32'(held_r));
          check("frame_cnt", 32'(FRAME_CNT), 32'(model_cnt));
          if (last_r >= 0) check("r_period", cyc - last_r, FRAME);
          last_r = cyc;
        end
      end
      m_psck = SCK;
      m_pws  = WS;
    end
  end

  task automatic resync();
    last_rise = -1;
    last_ws   = -1;
    last_l    = -1;
    last_r    = -1;
  endtask

  task automatic wait_r_strobe();
    int n0 = n_r;
    int k  = 0;
    while (n_r == n0 && k < 2 * FRAME) begin
      @(negedge CLK);
      k++;
    end
    check("wait_r", n_r - n0, 1);
  endtask

  task automatic wait_l_strobe();
    int n0 = n_l;
    int k  = 0;
    while (n_l == n0 && k < 2 * FRAME) begin
      @(negedge CLK);
      k++;
    end
    check("wait_l", n_l - n0, 1);
  endtask

  task automatic wait_ws_to(input logic v);
    logic p     = WS;
    int   k     = 0;
    int   found = 0;
    while (found == 0 && k < 2 * FRAME) begin
      @(negedge CLK);
      k++;
      if (p !== v && WS === v) found = 1;
      p = WS;
    end
    check("wait_ws", found, 1);
  endtask

  task automatic wait_sck_falls(input int n);
    logic p   = SCK;
    int   got = 0;
    int   k   = 0;
    while (got < n && k < 2 * FRAME) begin
      @(negedge CLK);
      k++;
      if (p && !SCK) got++;
      p = SCK;
    end
    check("wait_sck", got, n);
  endtask

  task automatic first_rise(input string tag);
    int k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (!SCK && k < 100);
    check(tag, k, DIV + 1);
  endtask

  initial begin
    int nl0;
    int nr0;
    int highs;

    RST = 1'b1;
    EN  = 1'b0;
    repeat (3) @(negedge CLK);

    RST = 1'b0;
    EN  = 1'b1;
    first_rise("first_rise");
    repeat (3) wait_r_strobe();
    check("fixed_l", 32'(SDATA_L), 32'(out_word(24'h123456)));
    check("fixed_r", 32'(SDATA_R), 32'(out_word(24'hFEDCBA)));
    check("fcnt_3", 32'(FRAME_CNT), 32'd3);

    word_mode = 0;
    repeat (4) wait_r_strobe();

    word_mode = 2;
    fill_mode = 1;
    repeat (2) wait_r_strobe();
    check("filler_l", 32'(SDATA_L), 32'(out_word(24'h0)));
    check("filler_r", 32'(SDATA_R), 32'(out_word(24'h0)));
    word_mode = 0;
    fill_mode = 0;

    wait_ws_to(1'b1);
    EN = 1'b0;
    repeat (20) @(negedge CLK);
    EN = 1'b1;
    nr0 = n_r;
    repeat (2 * FRAME) @(negedge CLK);
    check("nogap_r", n_r - nr0, 2);

    wait_ws_to(1'b0);
    wait_sck_falls(10);
    EN  = 1'b0;
    nl0 = n_l;
    nr0 = n_r;
    wait_ws_to(1'b0);
    check("drop_l", n_l - nl0, 1);
    check("drop_r", n_r - nr0, 1);
    nl0   = n_l;
    nr0   = n_r;
    highs = 0;
    repeat (2 * FRAME) begin
      @(negedge CLK);
      if (SCK || WS) highs++;
    end
    check("idle_sck_ws", highs, 0);
    check("idle_strobes", (n_l - nl0) + (n_r - nr0), 0);
    check("hold_l", 32'(SDATA_L), 32'(held_l));
    check("hold_r", 32'(SDATA_R), 32'(held_r));
    check("hold_fcnt", 32'(FRAME_CNT), 32'(model_cnt));

    resync();
    EN = 1'b1;
    first_rise("reenable_rise");
    repeat (2) wait_r_strobe();

    wait_ws_to(1'b1);
    wait_sck_falls(8);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    nl0 = n_l;
    nr0 = n_r;
    begin
      int k = 0;
      while (n_l == nl0 && n_r == nr0 && k < 2 * FRAME) begin
        @(negedge CLK);
        k++;
      end
    end
    check("rst_first_l", n_l - nl0, 1);
    check("rst_first_r", n_r - nr0, 0);
    wait_r_strobe();
    check("rst_fcnt_1", 32'(FRAME_CNT), 32'd1);

    wait_l_strobe();
    force dut.r_frame_cnt = 16'hFFFF;
    model_cnt = 16'hFFFF;
    @(negedge CLK);
    release dut.r_frame_cnt;
    @(negedge CLK);
    check("preload", 32'(FRAME_CNT), 32'hFFFF);
    wait_r_strobe();
    check("wrap", 32'(FRAME_CNT), 32'h0);

    repeat (4) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
